// File: rtl/ps2_pkg.sv
// Shared constants, modifier bit positions and FSM state encoding for the PS/2 scancode path.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  localparam logic [7:0] SC_SHIFT_L = 8'h12;
  localparam logic [7:0] SC_SHIFT_R = 8'h59;
  localparam logic [7:0] SC_CTRL    = 8'h14;
  localparam logic [7:0] SC_ALT     = 8'h11;

  localparam int MOD_LSHIFT = 0;
  localparam int MOD_RSHIFT = 1;
  localparam int MOD_LCTRL  = 2;
  localparam int MOD_RCTRL  = 3;
  localparam int MOD_LALT   = 4;
  localparam int MOD_RALT   = 5;

  // Pause is E1 followed by seven more bytes that carry no useful information.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } ps2_state_e;

  function automatic logic is_response(input logic [7:0] b);
    return (b == PS2_ACK) || (b == PS2_BAT_OK) || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_modifier_tracker.sv
// Holds the shift/ctrl/alt state, updated from every emitted key event (held or dropped).
module ps2_modifier_tracker
  import ps2_pkg::*;
(
  input  logic       ck,
  input  logic       reset,
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       brk,
  input  logic       strobe,
  output logic [5:0] mods
);

  logic [5:0] mods_q, mods_d;

  always_comb begin
    mods_d = mods_q;
    if (strobe) begin
      if (!ext && code == SC_SHIFT_L) mods_d[MOD_LSHIFT] = !brk;
      if (!ext && code == SC_SHIFT_R) mods_d[MOD_RSHIFT] = !brk;
      if (!ext && code == SC_CTRL)    mods_d[MOD_LCTRL]  = !brk;
      if ( ext && code == SC_CTRL)    mods_d[MOD_RCTRL]  = !brk;
      if (!ext && code == SC_ALT)     mods_d[MOD_LALT]   = !brk;
      if ( ext && code == SC_ALT)     mods_d[MOD_RALT]   = !brk;
    end
  end

  always_ff @(posedge ck) begin
    if (reset) mods_q <= '0;
    else       mods_q <= mods_d;
  end

  assign mods = mods_q;

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Turns the PS/2 byte stream into make/break key events with a one-deep valid/ready output,
// device-response reporting and an inter-byte timeout for partial prefixes.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       ck,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [5:0] mods,
  output logic [7:0] dev_resp,
  output logic       dev_resp_valid,
  output logic       overflow,
  output logic       timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e     state_q, state_d;
  logic [2:0]     skip_q, skip_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [7:0]     key_code_q, key_code_d;
  logic           key_ext_q, key_ext_d;
  logic           key_break_q, key_break_d;
  logic           key_valid_q, key_valid_d;
  logic [7:0]     dev_resp_q, dev_resp_d;
  logic           dev_resp_valid_q, dev_resp_valid_d;
  logic           overflow_q, overflow_d;
  logic           timeout_q, timeout_d;

  logic           emit;
  logic [7:0]     emit_code;
  logic           emit_ext;
  logic           emit_brk;

  always_comb begin
    state_d          = state_q;
    skip_d           = skip_q;
    tcnt_d           = tcnt_q;
    emit             = 1'b0;
    emit_code        = data_in;
    emit_ext         = 1'b0;
    emit_brk         = 1'b0;
    dev_resp_d       = dev_resp_q;
    dev_resp_valid_d = 1'b0;
    timeout_d        = 1'b0;

    if (data_valid) begin
      tcnt_d = '0;
      if (state_q != ST_PAUSE && is_response(data_in)) begin
        dev_resp_d       = data_in;
        dev_resp_valid_d = 1'b1;
        state_d          = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (data_in == PS2_EXT) begin
              state_d = ST_EXT;
            end else if (data_in == PS2_BRK) begin
              state_d = ST_BRK;
            end else if (data_in == PS2_PAUSE) begin
              state_d = ST_PAUSE;
              skip_d  = PAUSE_SKIP;
            end else begin
              emit = 1'b1;
            end
          end
          ST_EXT: begin
            if (data_in == PS2_BRK) begin
              state_d = ST_EXT_BRK;
            end else if (data_in != PS2_EXT) begin
              emit     = 1'b1;
              emit_ext = 1'b1;
              state_d  = ST_IDLE;
            end
          end
          ST_BRK, ST_EXT_BRK: begin
            if (data_in != PS2_BRK) begin
              emit     = 1'b1;
              emit_brk = 1'b1;
              emit_ext = (state_q == ST_EXT_BRK);
              state_d  = ST_IDLE;
            end
          end
          ST_PAUSE: begin
            if (skip_q == 3'd1) begin
              emit      = 1'b1;
              emit_code = PS2_PAUSE;
              skip_d    = '0;
              state_d   = ST_IDLE;
            end else begin
              skip_d = skip_q - 3'd1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else if (state_q != ST_IDLE) begin
      if (tcnt_q == CNT_LAST) begin
        state_d   = ST_IDLE;
        timeout_d = 1'b1;
        tcnt_d    = '0;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end else begin
      tcnt_d = '0;
    end
  end

  // One-deep event holding register; a new event while a held one is unaccepted is dropped.
  always_comb begin
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_break_d = key_break_q;
    key_valid_d = key_valid_q;
    overflow_d  = 1'b0;
    if (emit) begin
      if (!key_valid_q || key_ready) begin
        key_code_d  = emit_code;
        key_ext_d   = emit_ext;
        key_break_d = emit_brk;
        key_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (key_valid_q && key_ready) begin
      key_valid_d = 1'b0;
    end
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      skip_q           <= '0;
      tcnt_q           <= '0;
      key_code_q       <= '0;
      key_ext_q        <= 1'b0;
      key_break_q      <= 1'b0;
      key_valid_q      <= 1'b0;
      dev_resp_q       <= '0;
      dev_resp_valid_q <= 1'b0;
      overflow_q       <= 1'b0;
      timeout_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      skip_q           <= skip_d;
      tcnt_q           <= tcnt_d;
      key_code_q       <= key_code_d;
      key_ext_q        <= key_ext_d;
      key_break_q      <= key_break_d;
      key_valid_q      <= key_valid_d;
      dev_resp_q       <= dev_resp_d;
      dev_resp_valid_q <= dev_resp_valid_d;
      overflow_q       <= overflow_d;
      timeout_q        <= timeout_d;
    end
  end

  ps2_modifier_tracker u_mods (
    .ck     (ck),
    .reset  (reset),
    .code   (emit_code),
    .ext    (emit_ext),
    .brk    (emit_brk),
    .strobe (emit),
    .mods   (mods)
  );

  assign key_code       = key_code_q;
  assign key_ext        = key_ext_q;
  assign key_break      = key_break_q;
  assign key_valid      = key_valid_q;
  assign dev_resp       = dev_resp_q;
  assign dev_resp_valid = dev_resp_valid_q;
  assign overflow       = overflow_q;
  assign timeout        = timeout_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench: directed scenarios plus randomized byte traffic against a
// prefix-flag reference model of the scancode decoder.
module tb_ps2_scancode_decoder;

  localparam int T = 16;

  logic       ck = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       key_ready = 1'b0;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic [5:0] mods;
  logic [7:0] dev_resp;
  logic       dev_resp_valid;
  logic       overflow;
  logic       timeout;

  int total = 0;
  int bad = 0;

  // Reference model: prefix flags, pause bytes left, idle cycles since last byte.
  bit         seen_e0, seen_f0;
  int         pause_left;
  int         idle_cnt;
  logic [7:0] m_code;
  bit         m_ext, m_brk, m_valid;
  logic [5:0] m_mods;
  logic [7:0] m_dev;
  bit         m_devp, m_ovf, m_to;

  logic [7:0] pool [0:11];

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .ck             (ck),
    .reset          (reset),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .key_code       (key_code),
    .key_ext        (key_ext),
    .key_break      (key_break),
    .key_valid      (key_valid),
    .key_ready      (key_ready),
    .mods           (mods),
    .dev_resp       (dev_resp),
    .dev_resp_valid (dev_resp_valid),
    .overflow       (overflow),
    .timeout        (timeout)
  );

  always #5 ck = ~ck;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int modBit(input logic [7:0] code, input bit ext);
    if (!ext && code == 8'h12) return 0;
    if (!ext && code == 8'h59) return 1;
    if (!ext && code == 8'h14) return 2;
    if ( ext && code == 8'h14) return 3;
    if (!ext && code == 8'h11) return 4;
    if ( ext && code == 8'h11) return 5;
    return -1;
  endfunction

  function automatic bit isResp(input logic [7:0] b);
    return b == 8'hFA || b == 8'hAA || b == 8'hEE || b == 8'hFE || b == 8'h00 || b == 8'hFF;
  endfunction

  task automatic modelReset();
    seen_e0 = 0; seen_f0 = 0; pause_left = 0; idle_cnt = 0;
    m_code = 8'h00; m_ext = 0; m_brk = 0; m_valid = 0; m_mods = 6'h00;
    m_dev = 8'h00; m_devp = 0; m_ovf = 0; m_to = 0;
  endtask

  task automatic modelEmit(input logic [7:0] code, input bit ext, input bit brk, input bit rdy);
    int idx;
    idx = modBit(code, ext);
    if (code != 8'hE1 || ext || brk) begin
      if (idx >= 0) m_mods[idx] = !brk;
    end
    if (!m_valid || rdy) begin
      m_code = code; m_ext = ext; m_brk = brk; m_valid = 1;
    end else begin
      m_ovf = 1;
    end
  endtask

  task automatic modelStep(input bit dv, input logic [7:0] b, input bit rdy);
    bit emitted;
    emitted = 0;
    m_devp = 0; m_ovf = 0; m_to = 0;
    if (dv) begin
      idle_cnt = 0;
      if (pause_left > 0) begin
        pause_left--;
        if (pause_left == 0) begin modelEmit(8'hE1, 0, 0, rdy); emitted = 1; end
      end else if (isResp(b)) begin
        m_dev = b; m_devp = 1; seen_e0 = 0; seen_f0 = 0;
      end else if (seen_f0) begin
        if (b != 8'hF0) begin
          modelEmit(b, seen_e0, 1, rdy); emitted = 1; seen_e0 = 0; seen_f0 = 0;
        end
      end else if (b == 8'hF0) begin
        seen_f0 = 1;
      end else if (seen_e0) begin
        if (b != 8'hE0) begin modelEmit(b, 1, 0, rdy); emitted = 1; seen_e0 = 0; end
      end else if (b == 8'hE0) begin
        seen_e0 = 1;
      end else if (b == 8'hE1) begin
        pause_left = 7;
      end else begin
        modelEmit(b, 0, 0, rdy); emitted = 1;
      end
    end else if (seen_e0 || seen_f0 || pause_left > 0) begin
      idle_cnt++;
      if (idle_cnt == T) begin
        m_to = 1; idle_cnt = 0; seen_e0 = 0; seen_f0 = 0; pause_left = 0;
      end
    end
    if (!emitted && m_valid && rdy) m_valid = 0;
  endtask

  task automatic compareAll();
    checkOutput("key_valid", key_valid, m_valid);
    if (m_valid) begin
      checkOutput("key_code", key_code, m_code);
      checkOutput("key_ext", key_ext, m_ext);
      checkOutput("key_break", key_break, m_brk);
    end
    checkOutput("mods", mods, m_mods);
    checkOutput("dev_resp", dev_resp, m_dev);
    checkOutput("dev_resp_valid", dev_resp_valid, m_devp);
    checkOutput("overflow", overflow, m_ovf);
    checkOutput("timeout", timeout, m_to);
  endtask

  task automatic applyStimulus(input bit dv, input logic [7:0] b, input bit rdy);
    @(negedge ck);
    data_valid = dv;
    data_in    = b;
    key_ready  = rdy;
    @(posedge ck);
    modelStep(dv, b, rdy);
    #1;
    compareAll();
  endtask

  task automatic sendByte(input logic [7:0] b, input bit rdy);
    applyStimulus(1, b, rdy);
  endtask

  task automatic doReset();
    @(negedge ck);
    reset = 1; data_valid = 0; key_ready = 0;
    @(posedge ck);
    @(negedge ck);
    reset = 0;
    modelReset();
    compareAll();
    checkOutput("rst_key_code", key_code, 8'h00);
    checkOutput("rst_key_ext", key_ext, 1'b0);
    checkOutput("rst_key_break", key_break, 1'b0);
  endtask

  initial begin
    pool = '{8'h1C, 8'h32, 8'h12, 8'h59, 8'h14, 8'h11, 8'h75, 8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'hAA};
    modelReset();
    doReset();

    // Make then break of 1C.
    sendByte(8'h1C, 1);
    checkOutput("make_1c_code", key_code, 8'h1C);
    checkOutput("make_1c_valid", key_valid, 1'b1);
    sendByte(8'hF0, 1);
    sendByte(8'h1C, 1);
    checkOutput("brk_1c_break", key_break, 1'b1);

    // Extended break and right-ctrl tracking.
    sendByte(8'hE0, 1); sendByte(8'hF0, 1); sendByte(8'h75, 1);
    checkOutput("ext_brk_75", {key_code, key_ext, key_break}, {8'h75, 1'b1, 1'b1});
    sendByte(8'hE0, 1); sendByte(8'h14, 1);
    checkOutput("rctrl_set", mods[3], 1'b1);
    sendByte(8'hE0, 1); sendByte(8'hF0, 1); sendByte(8'h14, 1);
    checkOutput("rctrl_clr", mods[3], 1'b0);

    // Pause sequence.
    sendByte(8'hE1, 1); sendByte(8'h14, 1); sendByte(8'h77, 1); sendByte(8'hE1, 1);
    sendByte(8'hF0, 1); sendByte(8'h14, 1); sendByte(8'hF0, 1);
    checkOutput("pause_pending", key_valid, 1'b0);
    sendByte(8'h77, 1);
    checkOutput("pause_code", {key_valid, key_code}, {1'b1, 8'hE1});
    checkOutput("pause_mods", mods, 6'h00);

    // Overflow while consumer stalls.
    applyStimulus(0, 8'h00, 1);
    sendByte(8'h1C, 0);
    sendByte(8'h32, 0);
    checkOutput("ovf_pulse", overflow, 1'b1);
    checkOutput("ovf_held", key_code, 8'h1C);
    applyStimulus(0, 8'h00, 1);
    checkOutput("ovf_drain", key_valid, 1'b0);

    // Timeout after a lone E0, then a plain make and a response aborting a prefix.
    sendByte(8'hE0, 1);
    for (int i = 0; i < T; i++) applyStimulus(0, 8'h00, 1);
    checkOutput("timeout_pulse", timeout, 1'b1);
    sendByte(8'h1C, 1);
    checkOutput("post_to_ext", key_ext, 1'b0);
    sendByte(8'hF0, 1);
    sendByte(8'hFA, 1);
    checkOutput("resp_fa", {dev_resp_valid, dev_resp}, {1'b1, 8'hFA});
    checkOutput("resp_no_key", key_valid, 1'b0);

    // Reset mid-sequence.
    sendByte(8'hE0, 0); sendByte(8'hF0, 0);
    doReset();
    sendByte(8'h1C, 1);
    checkOutput("post_rst_make", {key_ext, key_break}, 2'b00);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        for (int g = 0; g < T + 4; g++) applyStimulus(0, 8'h00, 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 299) == 0) doReset();
      applyStimulus($urandom_range(0, 99) < 60, pool[$urandom_range(0, 11)],
                    $urandom_range(0, 99) < 70);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
